// File: rtl/sudoku_pkg.sv
// Shared constants and types for the 4x4 Sudoku datapath: cell encoding, base grid,
// blank-count table, LFSR taps and the blanking sequencer state.
package sudoku_pkg;

  localparam int CELL_W  = 2;
  localparam int N_CELLS = 16;
  localparam int IDX_W   = 4;
  localparam int BOARD_W = CELL_W * N_CELLS;
  localparam int CNT_W   = 4;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [BOARD_W-1:0] board_t;
  typedef logic [N_CELLS-1:0] mask_t;

  // Rows 0123 / 2301 / 1032 / 3210, cell i at [2i+1:2i].
  localparam board_t BASE_GRID = 32'h1BB1_4EE4;

  // x^8 + x^6 + x^5 + x^4 + 1, feedback from state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_BLANK = 1'b1
  } seq_state_e;

  function automatic logic [CNT_W-1:0] blank_count(input logic [1:0] diff);
    logic [CNT_W-1:0] n;
    case (diff)
      2'd0:    n = 4'd4;
      2'd1:    n = 4'd6;
      2'd2:    n = 4'd8;
      default: n = 4'd10;
    endcase
    return n;
  endfunction

  // Digit relabelling keeps every row, column and box a permutation.
  function automatic board_t make_solution(input cell_t offset);
    board_t sol;
    for (int i = 0; i < N_CELLS; i++) begin
      sol[CELL_W*i +: CELL_W] = BASE_GRID[CELL_W*i +: CELL_W] + offset;
    end
    return sol;
  endfunction

endpackage

// File: rtl/sudoku_lfsr.sv
// Fibonacci LFSR used to randomise the puzzle offset and the cells that get blanked.
module sudoku_lfsr #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   SEED  = 8'hA5,
  parameter logic [WIDTH-1:0]   TAPS  = 8'hB8
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_d, state_q;

  // NOTE: assign the default first so every path through always_comb drives state_d; a missing default infers a latch.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/sudoku_datapath.sv
// Board, solution and mask owner for the 4x4 Sudoku game, driven by the main FSM flags.
// Optional row/col/box duplicate detection is compiled in with `define CONFLICT_CHECK_EN.
module sudoku_datapath
  import sudoku_pkg::*;
#(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic          clka,
  input  logic          restart_n,
  input  logic          new_game,
  input  logic          gen_rand_flag,
  input  logic          set_board_flag,
  input  logic          set_diff_flag,
  input  logic          row_flag,
  input  logic          col_flag,
  input  logic          val_flag,
  input  logic          check_flag,
  input  logic [1:0]    user_in,
  output logic          busy,
  output logic          solved,
  output logic          rejected,
  output logic          conflict,
  output logic [31:0]   board,
  output logic [15:0]   filled_mask,
  output logic [15:0]   given_mask
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_en;

  board_t           board_d, board_q;
  mask_t            filled_d, filled_q;
  mask_t            given_d, given_q;
  cell_t            offset_d, offset_q;
  cell_t            row_d, row_q;
  cell_t            col_d, col_q;
  cell_t            val_d, val_q;
  logic [1:0]       diff_d, diff_q;
  seq_state_e       seq_d, seq_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rejected_d, rejected_q;
  logic             solved_d, solved_q;
  logic             board_prev_q, diff_prev_q, check_prev_q;

  board_t solution;
  idx_t   cell_idx;
  idx_t   blank_idx;
  logic   board_rise, diff_act, diff_fall, row_act, col_act, val_act, check_rise;
  logic   unused_lfsr_hi;

  assign busy    = (seq_q == SEQ_BLANK);
  assign lfsr_en = gen_rand_flag | busy;

  sudoku_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_W'(LFSR_TAPS_8))
  ) u_lfsr (
    .clka      (clka),
    .restart_n (restart_n),
    .en        (lfsr_en),
    .state     (lfsr_q)
  );

  assign blank_idx      = lfsr_q[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:IDX_W];
  assign cell_idx       = {row_q, col_q};
  assign solution       = make_solution(offset_q);

  // Each flag acts only when no higher-priority flag is high.
  assign board_rise = set_board_flag & ~board_prev_q & ~gen_rand_flag;
  assign diff_act   = set_diff_flag & ~gen_rand_flag & ~set_board_flag;
  assign diff_fall  = ~set_diff_flag & diff_prev_q;
  assign row_act    = row_flag & ~(gen_rand_flag | set_board_flag | set_diff_flag);
  assign col_act    = col_flag & ~(gen_rand_flag | set_board_flag | set_diff_flag | row_flag);
  assign val_act    = val_flag & ~(gen_rand_flag | set_board_flag | set_diff_flag | row_flag |
                                   col_flag);
  assign check_rise = check_flag & ~check_prev_q & ~busy &
                      ~(gen_rand_flag | set_board_flag | set_diff_flag | row_flag | col_flag |
                        val_flag);

  always_comb begin
    board_d    = board_q;
    filled_d   = filled_q;
    given_d    = given_q;
    offset_d   = offset_q;
    row_d      = row_q;
    col_d      = col_q;
    val_d      = val_q;
    diff_d     = diff_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    rejected_d = rejected_q;

    if (diff_act) diff_d = user_in;
    if (row_act)  row_d  = user_in;
    if (col_act)  col_d  = user_in;
    if (val_act)  val_d  = user_in;

    case (seq_q)
      SEQ_IDLE: begin
        if (diff_fall) begin
          seq_d = SEQ_BLANK;
          cnt_d = blank_count(diff_q);
        end
      end
      SEQ_BLANK: begin
        if (given_q[blank_idx]) begin
          given_d[blank_idx]  = 1'b0;
          filled_d[blank_idx] = 1'b0;
          cnt_d               = cnt_q - 4'd1;
          if (cnt_q == 4'd1) seq_d = SEQ_IDLE;
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase

    if (board_rise) begin
      offset_d   = lfsr_q[1:0];
      board_d    = make_solution(lfsr_q[1:0]);
      filled_d   = '1;
      given_d    = '1;
      rejected_d = 1'b0;
    end

    if (check_rise) begin
      if (given_q[cell_idx]) begin
        rejected_d = 1'b1;
      end else begin
        board_d[{cell_idx, 1'b0} +: CELL_W] = val_q;
        filled_d[cell_idx]                  = 1'b1;
        rejected_d                          = 1'b0;
      end
    end

    if (new_game) begin
      board_d    = '0;
      filled_d   = '0;
      given_d    = '0;
      offset_d   = '0;
      row_d      = '0;
      col_d      = '0;
      val_d      = '0;
      diff_d     = '0;
      seq_d      = SEQ_IDLE;
      cnt_d      = '0;
      rejected_d = 1'b0;
    end

    solved_d = ~new_game & (filled_q == '1) & (board_q == solution);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      board_q      <= '0;
      filled_q     <= '0;
      given_q      <= '0;
      offset_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      val_q        <= '0;
      diff_q       <= '0;
      seq_q        <= SEQ_IDLE;
      cnt_q        <= '0;
      rejected_q   <= 1'b0;
      solved_q     <= 1'b0;
      board_prev_q <= 1'b0;
      diff_prev_q  <= 1'b0;
      check_prev_q <= 1'b0;
    end else begin
      board_q      <= board_d;
      filled_q     <= filled_d;
      given_q      <= given_d;
      offset_q     <= offset_d;
      row_q        <= row_d;
      col_q        <= col_d;
      val_q        <= val_d;
      diff_q       <= diff_d;
      seq_q        <= seq_d;
      cnt_q        <= cnt_d;
      rejected_q   <= rejected_d;
      solved_q     <= solved_d;
      board_prev_q <= set_board_flag;
      diff_prev_q  <= set_diff_flag;
      check_prev_q <= check_flag;
    end
  end

`ifdef CONFLICT_CHECK_EN
  logic conflict_hit;
  logic conflict_d, conflict_q;

  // Any other filled cell sharing the target's row, column or 2x2 box with the same digit.
  always_comb begin
    conflict_hit = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (i != int'(cell_idx) && filled_q[i] && board_q[CELL_W*i +: CELL_W] == val_q &&
          ((i / 4) == int'(row_q) || (i % 4) == int'(col_q) ||
           ((i / 8) == int'(row_q[1]) && ((i % 4) / 2) == int'(col_q[1])))) begin
        conflict_hit = 1'b1;
      end
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (new_game) begin
      conflict_d = 1'b0;
    end else if (board_rise) begin
      conflict_d = 1'b0;
    end else if (check_rise && !given_q[cell_idx]) begin
      conflict_d = conflict_hit;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

  assign board       = board_q;
  assign filled_mask = filled_q;
  assign given_mask  = given_q;
  assign solved      = solved_q;
  assign rejected    = rejected_q;

endmodule

// File: tb/tb_sudoku_datapath.sv
// Directed self-checking bench for sudoku_datapath: reset, load, blanking, play, new_game.
module tb_sudoku_datapath;

  logic        clka = 1'b0;
  logic        restart_n;
  logic        new_game, gen_rand_flag, set_board_flag, set_diff_flag;
  logic        row_flag, col_flag, val_flag, check_flag;
  logic [1:0]  user_in;
  logic        busy, solved, rejected, conflict;
  logic [31:0] board;
  logic [15:0] filled_mask, given_mask;

  int checks = 0;
  int errors = 0;

  localparam int TIMEOUT = 2000;

  int base_tbl [16] = '{0, 1, 2, 3,  2, 3, 0, 1,  1, 0, 3, 2,  3, 2, 1, 0};

  typedef struct {
    int         gen_cycles;
    logic [1:0] diff;
    int         blanks;
  } vec_t;

  vec_t vecs [4];

  always #5 clka = ~clka;

  sudoku_datapath dut (
    .clka           (clka),
    .restart_n      (restart_n),
    .new_game       (new_game),
    .gen_rand_flag  (gen_rand_flag),
    .set_board_flag (set_board_flag),
    .set_diff_flag  (set_diff_flag),
    .row_flag       (row_flag),
    .col_flag       (col_flag),
    .val_flag       (val_flag),
    .check_flag     (check_flag),
    .user_in        (user_in),
    .busy           (busy),
    .solved         (solved),
    .rejected       (rejected),
    .conflict       (conflict),
    .board          (board),
    .filled_mask    (filled_mask),
    .given_mask     (given_mask)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] sol_val(input logic [1:0] offset, input int i);
    return 2'((base_tbl[i] + int'(offset)) % 4);
  endfunction

  function automatic logic [31:0] exp_board(input logic [1:0] offset);
    logic [31:0] b;
    for (int i = 0; i < 16; i++) b[2*i +: 2] = sol_val(offset, i);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic apply_reset();
    new_game = 0; gen_rand_flag = 0; set_board_flag = 0; set_diff_flag = 0;
    row_flag = 0; col_flag = 0; val_flag = 0; check_flag = 0; user_in = 0;
    restart_n = 0;
    cycle(2);
    restart_n = 1;
    cycle();
  endtask

  task automatic pulse_set_board();
    set_board_flag = 1; cycle(); set_board_flag = 0;
  endtask

  task automatic pulse_set_diff(input logic [1:0] d);
    user_in = d; set_diff_flag = 1; cycle();
    set_diff_flag = 0; cycle();
  endtask

  task automatic pulse_new_game();
    new_game = 1; cycle(); new_game = 0;
  endtask

  // Leaves the bench just after the edge that performs the write.
  task automatic write_cell(input int idx, input logic [1:0] v);
    user_in = 2'(idx / 4); row_flag = 1; cycle(); row_flag = 0;
    user_in = 2'(idx % 4); col_flag = 1; cycle(); col_flag = 0;
    user_in = v;           val_flag = 1; cycle(); val_flag = 0;
    check_flag = 1; cycle(); check_flag = 0;
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    while (busy && n < TIMEOUT) begin
      cycle();
      n++;
    end
    if (n >= TIMEOUT) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  l;
    logic [15:0] mask;
    int          cnt, k, n, first_given, first_blank, last_blank;

    vecs[0] = '{gen_cycles: 0, diff: 2'd0, blanks: 4};
    vecs[1] = '{gen_cycles: 3, diff: 2'd1, blanks: 6};
    vecs[2] = '{gen_cycles: 5, diff: 2'd3, blanks: 10};
    vecs[3] = '{gen_cycles: 1, diff: 2'd2, blanks: 8};

    apply_reset();
    check("rst_board",    board,             32'h0);
    check("rst_filled",   32'(filled_mask),  32'h0);
    check("rst_given",    32'(given_mask),   32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_solved",   32'(solved),       32'h0);
    check("rst_rejected", 32'(rejected),     32'h0);
    check("rst_conflict", 32'(conflict),     32'h0);
    check("rst_lfsr",     32'(dut.lfsr_q),   32'hA5);

    // Load with the seed untouched: offset = A5[1:0] = 1.
    pulse_set_board();
    check("load_board",  board,            exp_board(2'd1));
    check("load_cell0",  32'(board[1:0]),  32'd1);
    check("load_cell15", 32'(board[31:30]), 32'd1);
    check("load_filled", 32'(filled_mask), 32'hFFFF);
    check("load_given",  32'(given_mask),  32'hFFFF);

    // Predict the blanking walk from the LFSR sequence.
    l = 8'hA5; mask = 16'hFFFF; cnt = 8; k = 0;
    while (cnt > 0) begin
      if (mask[l[3:0]]) begin
        mask[l[3:0]] = 1'b0;
        cnt--;
      end
      l = lfsr_step(l);
      k++;
    end

    pulse_set_diff(2'd2);
    check("blank_busy_start", 32'(busy), 32'd1);
    wait_not_busy(n);
    check("blank_cycles",  n,                          k);
    check("blank_filled",  32'(filled_mask),           32'(mask));
    check("blank_given",   32'(given_mask),            32'(mask));
    check("blank_pop",     $countones(filled_mask),    8);
    check("blank_board",   board,                      exp_board(2'd1));
    check("blank_lfsr",    32'(dut.lfsr_q),            32'(l));

    first_given = -1; first_blank = -1; last_blank = -1;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) first_given = i;
      else         first_blank = i;
    end
    for (int i = 0; i < 16; i++) if (!mask[i]) last_blank = i;

    // Writing a given cell is refused.
    write_cell(first_given, sol_val(2'd1, first_given) + 2'd1);
    check("given_rejected", 32'(rejected),    32'd1);
    check("given_board",    board,            exp_board(2'd1));
    check("given_filled",   32'(filled_mask), 32'(mask));
    cycle();
    check("given_solved",   32'(solved),      32'd0);

    // Fill every blank with its solution digit.
    for (int i = 0; i < 16; i++) begin
      if (!mask[i]) begin
        write_cell(i, sol_val(2'd1, i));
        check($sformatf("fill_rej_%0d", i),  32'(rejected), 32'd0);
        check($sformatf("fill_conf_%0d", i), 32'(conflict), 32'd0);
        if (i == last_blank) begin
          check("solved_early", 32'(solved), 32'd0);
          cycle();
          check("solved_late",  32'(solved), 32'd1);
        end
      end
    end
    check("fill_filled", 32'(filled_mask), 32'hFFFF);
    check("fill_given",  32'(given_mask),  32'(mask));
    check("fill_board",  board,            exp_board(2'd1));

    // Overwrite a non-given cell with a digit already used in its row.
    write_cell(first_blank, sol_val(2'd1, first_blank) + 2'd1);
    check("wrong_rejected", 32'(rejected), 32'd0);
`ifdef CONFLICT_CHECK_EN
    check("wrong_conflict", 32'(conflict), 32'd1);
`else
    check("wrong_conflict", 32'(conflict), 32'd0);
`endif
    cycle();
    check("wrong_solved", 32'(solved), 32'd0);

    pulse_new_game();
    check("ng_board",    board,            32'h0);
    check("ng_filled",   32'(filled_mask), 32'h0);
    check("ng_given",    32'(given_mask),  32'h0);
    check("ng_solved",   32'(solved),      32'd0);
    check("ng_conflict", 32'(conflict),    32'd0);
    check("ng_rejected", 32'(rejected),    32'd0);

    // new_game mid-blanking returns the sequencer to idle.
    pulse_set_board();
    pulse_set_diff(2'd0);
    check("abort_busy_start", 32'(busy), 32'd1);
    pulse_new_game();
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_given", 32'(given_mask), 32'h0);
    cycle(5);
    check("abort_busy_hold",  32'(busy),        32'd0);
    check("abort_filled_hold", 32'(filled_mask), 32'h0);

    // Per difficulty: LFSR advance under gen_rand, offset pick, blank count.
    for (int v = 0; v < 4; v++) begin
      apply_reset();
      l = 8'hA5;
      if (vecs[v].gen_cycles > 0) begin
        gen_rand_flag = 1;
        cycle(vecs[v].gen_cycles);
        gen_rand_flag = 0;
        for (int j = 0; j < vecs[v].gen_cycles; j++) l = lfsr_step(l);
      end
      check($sformatf("tbl%0d_lfsr", v), 32'(dut.lfsr_q), 32'(l));
      pulse_set_board();
      check($sformatf("tbl%0d_board", v), board, exp_board(l[1:0]));
      pulse_set_diff(vecs[v].diff);
      wait_not_busy(n);
      check($sformatf("tbl%0d_pop", v), $countones(filled_mask), 16 - vecs[v].blanks);
      check($sformatf("tbl%0d_given", v), 32'(given_mask), 32'(filled_mask));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
